// File: rtl/text_writer_if.sv
//==============================================================================
// Module      : text_writer_if
// Description : Character-stream handshake plus RAM write / cursor status
//               bundle for the text_writer block.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface text_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic [7:0]  in_colr;
    logic [11:0] wr_addr;
    logic [7:0]  wr_char;
    logic [7:0]  wr_colr;
    logic        wren_ms;
    logic        wren_mc;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    // Character source side
    modport master (
        output in_valid, in_char, in_colr,
        input  in_ready, wr_addr, wr_char, wr_colr, wren_ms, wren_mc,
               cursor_x, cursor_y, busy
    );

    // text_writer side
    modport slave (
        input  in_valid, in_char, in_colr,
        output in_ready, wr_addr, wr_char, wr_colr, wren_ms, wren_mc,
               cursor_x, cursor_y, busy
    );
endinterface

`default_nettype wire

// File: rtl/text_writer.sv
//==============================================================================
// Module      : text_writer
// Description : Accepts a character stream (code + colour) and writes the
//               text-mode screen/colour RAMs at a hardware cursor. Handles
//               CR, LF and BS; optional form-feed screen clear is enabled by
//               defining the macro TEXT_WRITER_CLEAR_EN.
//               RAM address layout: addr[6:0] = column, addr[11:7] = row.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module text_writer #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 25,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  wire logic     clk,
    input  wire logic     rst,
    text_writer_if.slave  bus
);

    localparam logic [6:0] c_last_col = 7'(COLS - 1);
    localparam logic [4:0] c_last_row = 5'(ROWS - 1);
    localparam logic [7:0] c_code_cr  = 8'h0D;
    localparam logic [7:0] c_code_lf  = 8'h0A;
    localparam logic [7:0] c_code_bs  = 8'h08;

    logic        r_in_ready;
    logic [11:0] r_wr_addr;
    logic [7:0]  r_wr_char;
    logic [7:0]  r_wr_colr;
    logic        r_wren;
    logic [6:0]  r_cur_x;
    logic [4:0]  r_cur_y;

    logic        w_xfer;
    logic [4:0]  w_y_next;

`ifdef TEXT_WRITER_CLEAR_EN
    localparam logic [7:0] c_code_ff = 8'h0C;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic [6:0]  r_clr_x;
    logic [4:0]  r_clr_y;
    logic [7:0]  r_clr_colr;
`endif

    // A transfer only happens while ready is advertised, so CLEAR ignores in_valid
    assign w_xfer   = bus.in_valid && r_in_ready;
    assign w_y_next = (r_cur_y == c_last_row) ? 5'd0 : r_cur_y + 5'd1;

    // Cursor, write-port and clear sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready <= 1'b1;
            r_wr_addr  <= 12'd0;
            r_wr_char  <= 8'd0;
            r_wr_colr  <= 8'd0;
            r_wren     <= 1'b0;
            r_cur_x    <= 7'd0;
            r_cur_y    <= 5'd0;
`ifdef TEXT_WRITER_CLEAR_EN
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_clr_x    <= 7'd0;
            r_clr_y    <= 5'd0;
            r_clr_colr <= 8'd0;
`endif
        end else begin
            r_wren <= 1'b0;
`ifdef TEXT_WRITER_CLEAR_EN
            if (r_state == S_CLEAR) begin
                // One blank per cycle, row-major, only over the visible area
                r_wr_addr <= {r_clr_y, r_clr_x};
                r_wr_char <= BLANK_CHAR;
                r_wr_colr <= r_clr_colr;
                r_wren    <= 1'b1;
                if (r_clr_x == c_last_col) begin
                    r_clr_x <= 7'd0;
                    if (r_clr_y == c_last_row) begin
                        r_clr_y    <= 5'd0;
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_cur_x    <= 7'd0;
                        r_cur_y    <= 5'd0;
                    end else begin
                        r_clr_y <= r_clr_y + 5'd1;
                    end
                end else begin
                    r_clr_x <= r_clr_x + 7'd1;
                end
            end else
`endif
            if (w_xfer) begin
                case (bus.in_char)
                    c_code_cr: begin
                        r_cur_x <= 7'd0;
                    end
                    c_code_lf: begin
                        r_cur_x <= 7'd0;
                        r_cur_y <= w_y_next;
                    end
                    c_code_bs: begin
                        // Backspace blanks the cell it moves onto; at home it is a no-op
                        if (r_cur_x != 7'd0) begin
                            r_cur_x   <= r_cur_x - 7'd1;
                            r_wr_addr <= {r_cur_y, r_cur_x - 7'd1};
                            r_wr_char <= BLANK_CHAR;
                            r_wr_colr <= bus.in_colr;
                            r_wren    <= 1'b1;
                        end else if (r_cur_y != 5'd0) begin
                            r_cur_x   <= c_last_col;
                            r_cur_y   <= r_cur_y - 5'd1;
                            r_wr_addr <= {r_cur_y - 5'd1, c_last_col};
                            r_wr_char <= BLANK_CHAR;
                            r_wr_colr <= bus.in_colr;
                            r_wren    <= 1'b1;
                        end
                    end
`ifdef TEXT_WRITER_CLEAR_EN
                    c_code_ff: begin
                        r_clr_colr <= bus.in_colr;
                        r_clr_x    <= 7'd0;
                        r_clr_y    <= 5'd0;
                        r_state    <= S_CLEAR;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
`endif
                    default: begin
                        r_wr_addr <= {r_cur_y, r_cur_x};
                        r_wr_char <= bus.in_char;
                        r_wr_colr <= bus.in_colr;
                        r_wren    <= 1'b1;
                        if (r_cur_x == c_last_col) begin
                            r_cur_x <= 7'd0;
                            r_cur_y <= w_y_next;
                        end else begin
                            r_cur_x <= r_cur_x + 7'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_char  = r_wr_char;
    assign bus.wr_colr  = r_wr_colr;
    assign bus.wren_ms  = r_wren;
    assign bus.wren_mc  = r_wren;
    assign bus.cursor_x = r_cur_x;
    assign bus.cursor_y = r_cur_y;
`ifdef TEXT_WRITER_CLEAR_EN
    assign bus.busy     = r_busy;
`else
    assign bus.busy     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_text_writer.sv
//==============================================================================
// Module      : tb_text_writer
// Description : Self-checking bench for text_writer with a write scoreboard.
//               Clear scenarios are built when TEXT_WRITER_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_text_writer;

    localparam int COLS = 80;
    localparam int ROWS = 25;
    localparam logic [7:0] BLANK = 8'h20;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  ch;
        logic [7:0]  co;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    text_writer_if bus();

    text_writer #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .BLANK_CHAR (BLANK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int  checks     = 0;
    int  errors     = 0;
    int  wren_cnt   = 0;
    int  exp_writes = 0;
    int  mx = 0;
    int  my = 0;
    wr_t exp_q[$];

    // Scoreboard: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        checks++;
        if (bus.wren_mc !== bus.wren_ms) begin
            errors++;
            $display("FAIL wren_mc_eq got %b want %b", bus.wren_mc, bus.wren_ms);
        end
        if (bus.wren_ms === 1'b1) begin
            wren_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got addr=%h ch=%h co=%h want no write",
                         bus.wr_addr, bus.wr_char, bus.wr_colr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({bus.wr_addr, bus.wr_char, bus.wr_colr} !== e) begin
                    errors++;
                    $display("FAIL sb_write got addr=%h ch=%h co=%h want addr=%h ch=%h co=%h",
                             bus.wr_addr, bus.wr_char, bus.wr_colr, e.addr, e.ch, e.co);
                end
            end
        end
    end

    // Reference behaviour of one accepted transfer
    task automatic model_xfer(input logic [7:0] ch, input logic [7:0] co);
        wr_t w;
        case (ch)
            8'h0D: mx = 0;
            8'h0A: begin
                mx = 0;
                my = (my == ROWS - 1) ? 0 : my + 1;
            end
            8'h08: begin
                if (mx > 0) begin
                    mx = mx - 1;
                    w = '{addr: 12'(my * 128 + mx), ch: BLANK, co: co};
                    exp_q.push_back(w); exp_writes++;
                end else if (my > 0) begin
                    mx = COLS - 1;
                    my = my - 1;
                    w = '{addr: 12'(my * 128 + mx), ch: BLANK, co: co};
                    exp_q.push_back(w); exp_writes++;
                end
            end
`ifdef TEXT_WRITER_CLEAR_EN
            8'h0C: begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) begin
                        w = '{addr: 12'(r * 128 + c), ch: BLANK, co: co};
                        exp_q.push_back(w); exp_writes++;
                    end
                mx = 0;
                my = 0;
            end
`endif
            default: begin
                w = '{addr: 12'(my * 128 + mx), ch: ch, co: co};
                exp_q.push_back(w); exp_writes++;
                if (mx == COLS - 1) begin
                    mx = 0;
                    my = (my == ROWS - 1) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
        endcase
    endtask

    // Present one character; returns just after the edge that accepts it
    task automatic send(input logic [7:0] ch, input logic [7:0] co);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_char  = ch;
        bus.in_colr  = co;
        while (bus.in_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout got in_ready=%b want 1", bus.in_ready);
        end else begin
            model_xfer(ch, co);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_cursor(input string name);
        checks++;
        if (bus.cursor_x !== 7'(mx) || bus.cursor_y !== 5'(my)) begin
            errors++;
            $display("FAIL %s got (%0d,%0d) want (%0d,%0d)", name,
                     bus.cursor_x, bus.cursor_y, mx, my);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.wr_addr !== 12'h000 || bus.wr_char !== 8'h00 ||
            bus.wr_colr !== 8'h00 || bus.wren_ms !== 1'b0 || bus.wren_mc !== 1'b0 ||
            bus.busy !== 1'b0 || bus.cursor_x !== 7'd0 || bus.cursor_y !== 5'd0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b a=%h c=%h k=%h we=%b%b busy=%b cur=(%0d,%0d) want rdy=1 rest 0",
                     bus.in_ready, bus.wr_addr, bus.wr_char, bus.wr_colr, bus.wren_ms,
                     bus.wren_mc, bus.busy, bus.cursor_x, bus.cursor_y);
        end
        rst = 1'b0;
        mx = 0; my = 0;
        exp_q.delete();
    endtask

    task automatic test_single();
        send(8'h41, 8'h1F);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.wr_addr !== 12'h000 || bus.wr_char !== 8'h41 || bus.wr_colr !== 8'h1F ||
            bus.wren_ms !== 1'b1 || bus.wren_mc !== 1'b1) begin
            errors++;
            $display("FAIL single_write got a=%h c=%h k=%h we=%b%b want a=000 c=41 k=1f we=11",
                     bus.wr_addr, bus.wr_char, bus.wr_colr, bus.wren_ms, bus.wren_mc);
        end
        checks++;
        if (bus.cursor_x !== 7'd1 || bus.cursor_y !== 5'd0) begin
            errors++;
            $display("FAIL single_cursor got (%0d,%0d) want (1,0)", bus.cursor_x, bus.cursor_y);
        end
        @(negedge clk);
        checks++;
        if (bus.wren_ms !== 1'b0 || bus.wr_char !== 8'h41) begin
            errors++;
            $display("FAIL single_hold got we=%b c=%h want we=0 c=41", bus.wren_ms, bus.wr_char);
        end
        send(8'h08, 8'h1F);   // back to home, blanking (0,0)
        idle(2);
        check_cursor("single_home");
    endtask

    task automatic test_back_to_back();
        int base;
        base = wren_cnt;
        for (int i = 0; i < COLS; i++) send(8'(8'h30 + (i % 40)), 8'(i));
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.wr_addr !== 12'h04F || bus.wren_ms !== 1'b1) begin
            errors++;
            $display("FAIL line_last got a=%h we=%b want a=04f we=1", bus.wr_addr, bus.wren_ms);
        end
        checks++;
        if (bus.cursor_x !== 7'd0 || bus.cursor_y !== 5'd1) begin
            errors++;
            $display("FAIL line_cursor got (%0d,%0d) want (0,1)", bus.cursor_x, bus.cursor_y);
        end
        @(negedge clk);
        checks++;
        if (wren_cnt - base !== COLS) begin
            errors++;
            $display("FAIL line_count got %0d want %0d", wren_cnt - base, COLS);
        end
        base = wren_cnt;
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 8'h00);
        idle(2);
        checks++;
        if (bus.cursor_x !== 7'd0 || bus.cursor_y !== 5'd0 || wren_cnt != base) begin
            errors++;
            $display("FAIL lf_wrap got (%0d,%0d) writes=%0d want (0,0) writes=0",
                     bus.cursor_x, bus.cursor_y, wren_cnt - base);
        end
    endtask

    task automatic test_controls();
        int base;
        for (int i = 0; i < 3; i++) send(8'h0A, 8'h00);
        for (int i = 0; i < 5; i++) send(8'h61, 8'h2E);
        idle(2);
        check_cursor("ctl_setup");
        base = wren_cnt;
        send(8'h0D, 8'h00);
        idle(2);
        checks++;
        if (bus.cursor_x !== 7'd0 || bus.cursor_y !== 5'd3 || wren_cnt != base) begin
            errors++;
            $display("FAIL cr got (%0d,%0d) writes=%0d want (0,3) writes=0",
                     bus.cursor_x, bus.cursor_y, wren_cnt - base);
        end
        send(8'h08, 8'h4A);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.wren_ms !== 1'b1 || bus.wr_addr !== 12'h14F || bus.wr_char !== 8'h20 ||
            bus.wr_colr !== 8'h4A || bus.cursor_x !== 7'd79 || bus.cursor_y !== 5'd2) begin
            errors++;
            $display("FAIL bs_row got we=%b a=%h c=%h k=%h cur=(%0d,%0d) want we=1 a=14f c=20 k=4a cur=(79,2)",
                     bus.wren_ms, bus.wr_addr, bus.wr_char, bus.wr_colr,
                     bus.cursor_x, bus.cursor_y);
        end
        send(8'h0A, 8'h00);
        for (int i = 0; i < ROWS - 3; i++) send(8'h0A, 8'h00);
        idle(2);
        check_cursor("ctl_home");
        base = wren_cnt;
        send(8'h08, 8'h11);
        idle(2);
        checks++;
        if (bus.cursor_x !== 7'd0 || bus.cursor_y !== 5'd0 || wren_cnt != base) begin
            errors++;
            $display("FAIL bs_home got (%0d,%0d) writes=%0d want (0,0) writes=0",
                     bus.cursor_x, bus.cursor_y, wren_cnt - base);
        end
    endtask

`ifdef TEXT_WRITER_CLEAR_EN
    task automatic test_clear();
        int base;
        int low;
        for (int i = 0; i < 10; i++) send(8'h0A, 8'h00);
        for (int i = 0; i < 10; i++) send(8'h7A, 8'h05);
        idle(2);
        checks++;
        if (bus.cursor_x !== 7'd10 || bus.cursor_y !== 5'd10) begin
            errors++;
            $display("FAIL clr_setup got (%0d,%0d) want (10,10)", bus.cursor_x, bus.cursor_y);
        end
        base = wren_cnt;
        send(8'h0C, 8'h07);
        @(negedge clk);
        bus.in_valid = 1'b1;   // must be ignored during the clear
        bus.in_char  = 8'h41;
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_start got busy=%b rdy=%b want busy=1 rdy=0", bus.busy, bus.in_ready);
        end
        low = 1;
        while (bus.in_ready !== 1'b1 && low < 3000) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b1) low++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (low != COLS * ROWS) begin
            errors++;
            $display("FAIL clr_ready_low got %0d want %0d", low, COLS * ROWS);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wren_cnt - base != COLS * ROWS || exp_q.size() != 0) begin
            errors++;
            $display("FAIL clr_count got %0d pending=%0d want %0d pending=0",
                     wren_cnt - base, exp_q.size(), COLS * ROWS);
        end
        checks++;
        if (bus.cursor_x !== 7'd0 || bus.cursor_y !== 5'd0 || bus.busy !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_done got cur=(%0d,%0d) busy=%b rdy=%b want (0,0) busy=0 rdy=1",
                     bus.cursor_x, bus.cursor_y, bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_reset_in_clear();
        send(8'h0A, 8'h00);
        send(8'h0C, 8'h3C);
        idle(100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        mx = 0; my = 0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.wren_ms !== 1'b0 ||
            bus.cursor_x !== 7'd0 || bus.cursor_y !== 5'd0) begin
            errors++;
            $display("FAIL rst_in_clear got busy=%b rdy=%b we=%b cur=(%0d,%0d) want 0 1 0 (0,0)",
                     bus.busy, bus.in_ready, bus.wren_ms, bus.cursor_x, bus.cursor_y);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.wren_ms !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_clear_after got we=%b busy=%b want 0 0", bus.wren_ms, bus.busy);
        end
    endtask
`endif

    task automatic test_random();
        int base_w;
        int base_e;
        logic [7:0] ch;
        base_w = wren_cnt;
        base_e = exp_writes;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 5))
                0: ch = 8'h0D;
                1: ch = 8'h0A;
                2, 3: ch = 8'h08;
                default: begin
                    ch = 8'($urandom_range(0, 255));
`ifdef TEXT_WRITER_CLEAR_EN
                    if (ch == 8'h0C) ch = 8'h2A;
`endif
                end
            endcase
            send(ch, 8'($urandom_range(0, 255)));
            #1;
            checks++;
            if (bus.cursor_x >= 7'(COLS) || bus.cursor_y >= 5'(ROWS)) begin
                errors++;
                $display("FAIL rnd_range got (%0d,%0d) want x<%0d y<%0d",
                         bus.cursor_x, bus.cursor_y, COLS, ROWS);
            end
        end
        idle(3);
        check_cursor("rnd_cursor");
        checks++;
        if (wren_cnt - base_w != exp_writes - base_e || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_count got %0d pending=%0d want %0d",
                     wren_cnt - base_w, exp_q.size(), exp_writes - base_e);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        bus.in_colr  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_controls();
`ifdef TEXT_WRITER_CLEAR_EN
        test_clear();
        test_reset_in_clear();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
